irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: VEC_BASE, default 8'h40, autovector base; source i is reported as vector VEC_BASE+i.
REQ-002 Parameter: SPUR_VEC, default 8'h18, vector returned when no source matches an acknowledge.
REQ-003 Port: clk  in  1  single system clock; all flops update on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: irq_n  in  4  active-low level requests from peripherals, e.g. a timer's int_n; asynchronous to clk.
REQ-006 Port: ipl_n  out  3  active-low encoded priority level presented to the 68000.
REQ-007 Port: iack_req  in  1  level, high for the duration of a CPU interrupt-acknowledge cycle.
REQ-008 Port: iack_lvl  in  3  level being acknowledged (CPU A3..A1); valid while iack_req is high.
REQ-009 Port: vec  out  8  vector number for the acknowledge; valid when vec_valid is high.
REQ-010 Port: vec_valid  out  1  one-cycle strobe qualifying vec.
REQ-011 Port: ack_src  out  4  one-hot, one-cycle clear pulse to the acknowledged source; invert externally to drive rst_int_n.
REQ-012 Port: cfg_we  in  1  register write strobe.
REQ-013 Port: cfg_addr  in  2  register select.
REQ-014 Port: cfg_wdata  in  8  write data.
REQ-015 Port: cfg_rdata  out  8  combinational read data for cfg_addr.

Function
REQ-016 Register map: 0 = MASK {4'b0, mask[3:0]} RW; 1 = PEND {4'b0, pend[3:0]} RO, writes ignored; 2 = LVL01 {1'b0, lvl1[2:0], 1'b0, lvl0[2:0]} RW; 3 = LVL23, same layout for sources 3 and 2.
REQ-017 Each irq_n bit passes through a 2-flop synchronizer; sync flops reset to 1.
REQ-018 pend[i] = ~irq_sync[i] & mask[i] & (lvl[i] != 0); a level of 0 disables the source.
REQ-019 Priority: effective level = maximum lvl[i] over pending i; 0 if none pending.
REQ-020 ipl_n is registered and equals ~(effective level); it updates every cycle, including during acknowledge.
REQ-021 Latency: an irq_n falling edge reaches ipl_n 3 clk edges later (2 sync + 1 output register).
REQ-022 A register write takes effect on the edge it is sampled; pend and ipl_n reflect it one cycle later.
REQ-023 FSM states: IDLE, LOOKUP, RESP, WAIT.
REQ-024 IDLE -> LOOKUP when iack_req=1; iack_lvl is captured on that edge.
REQ-025 LOOKUP -> RESP unconditionally; selects the lowest-index pending source whose lvl equals the captured level, using current pend.
REQ-026 In RESP: vec_valid=1 for exactly one cycle.
REQ-027 In RESP with a match: vec=VEC_BASE+idx and ack_src[idx]=1 in the same cycle.
REQ-028 In RESP with no match: vec=SPUR_VEC and ack_src=0.
REQ-029 RESP -> WAIT unconditionally.
REQ-030 WAIT -> IDLE when iack_req=0; while in WAIT, further iack_req high produces no new response.
REQ-031 vec holds its last value until the next RESP; vec_valid and ack_src are 0 outside RESP.
REQ-032 Same-level ties: the lower index wins both in the lookup and for the ack pulse.
REQ-033 If a source deasserts between LOOKUP and RESP, the lookup result already captured stands.
REQ-034 A cfg write coincident with LOOKUP is not visible to that lookup.
REQ-035 VEC_BASE+idx is computed modulo 256.

Reset
REQ-036 On rst=1 at a clk edge: mask=0, all lvl=0, sync flops=1, ipl_n=3'b111, vec=8'h00, vec_valid=0, ack_src=0, state=IDLE.
REQ-037 Reset mid-acknowledge aborts the cycle; no vec_valid or ack_src pulse follows; the next iack_req starts from IDLE.

Verification
REQ-038 lvl0=5, mask=1, irq_n[0] driven 0 -> ipl_n=3'b010 three edges later; irq_n[0] driven 1 -> ipl_n=3'b111 three edges later.
REQ-039 lvl1=3 and lvl2=6, both pending -> ipl_n=3'b001; iack_req with iack_lvl=6 -> vec=8'h42, ack_src=4'b0100, both two edges after the request.
REQ-040 lvl0=lvl3=4, both pending, iack_lvl=4 -> vec=8'h40, ack_src=4'b0001; ipl_n stays 3'b011 while source 3 remains pending.
REQ-041 iack_lvl=2 with no level-2 source pending -> vec=8'h18, vec_valid pulses once, ack_src=0.
REQ-042 iack_req held high for 10 cycles -> exactly one vec_valid pulse; a second request after a low cycle -> a second pulse.
REQ-043 rst asserted in the LOOKUP state -> no pulse, ipl_n=3'b111, all registers read 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// 68000-style autovectored interrupt controller for four level-triggered sources.
// Latency: irq_n to ipl_n 3 edges; iack_req to vec/ack_src strobe 2 edges.
// Backpressure: none; one response per acknowledge cycle, re-armed once iack_req drops.
module irq_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'h40,
  parameter logic [7:0] SPUR_VEC = 8'h18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_n,
  output logic [2:0] ipl_n,
  input  logic       iack_req,
  input  logic [2:0] iack_lvl,
  output logic [7:0] vec,
  output logic       vec_valid,
  output logic [3:0] ack_src,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] mask_q;
  logic [2:0] lvl_q [4];
  logic [3:0] sync1_q, sync2_q;
  logic [2:0] ipl_q, ipl_d;
  logic [2:0] cap_lvl_q, cap_lvl_d;
  logic [7:0] vec_q, vec_d;
  logic       vld_q, vld_d;
  logic [3:0] ack_q, ack_d;

  logic [3:0] pend;
  logic [2:0] eff_lvl;
  logic       hit;
  logic [1:0] hit_idx;
  logic       unused_wdata;

  // Bits 7 and 3 of the write data have no storage behind them.
  assign unused_wdata = ^{cfg_wdata[7], cfg_wdata[3]};

  // Two-flop synchronizer for the asynchronous request lines; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= irq_n;
      sync2_q <= sync1_q;
    end
  end

  // Configuration registers: mask and per-source priority level.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      for (int i = 0; i < 4; i++) lvl_q[i] <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0: mask_q <= cfg_wdata[3:0];
        2'd2: begin
          lvl_q[0] <= cfg_wdata[2:0];
          lvl_q[1] <= cfg_wdata[6:4];
        end
        2'd3: begin
          lvl_q[2] <= cfg_wdata[2:0];
          lvl_q[3] <= cfg_wdata[6:4];
        end
        default: ;
      endcase
    end
  end

  // Combinational register read-back.
  always_comb begin
    cfg_rdata = 8'h00;
    case (cfg_addr)
      2'd0: cfg_rdata = {4'b0, mask_q};
      2'd1: cfg_rdata = {4'b0, pend};
      2'd2: cfg_rdata = {1'b0, lvl_q[1], 1'b0, lvl_q[0]};
      2'd3: cfg_rdata = {1'b0, lvl_q[3], 1'b0, lvl_q[2]};
      default: cfg_rdata = 8'h00;
    endcase
  end

  // Pending sources and the highest pending level; a level of 0 disables a source.
  always_comb begin
    eff_lvl = 3'd0;
    for (int i = 0; i < 4; i++) begin
      pend[i] = ~sync2_q[i] & mask_q[i] & (lvl_q[i] != 3'd0);
      if (pend[i] && (lvl_q[i] > eff_lvl)) eff_lvl = lvl_q[i];
    end
    ipl_d = ~eff_lvl;
  end

  // Lowest-index pending source at the captured level; scanning downward lets index 0 win ties.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i] && (lvl_q[i] == cap_lvl_q)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  // Acknowledge FSM next state; the response is registered so it appears during RESP.
  always_comb begin
    state_d   = state_q;
    cap_lvl_d = cap_lvl_q;
    vec_d     = vec_q;
    vld_d     = 1'b0;
    ack_d     = 4'b0;
    case (state_q)
      IDLE: begin
        if (iack_req) begin
          state_d   = LOOKUP;
          cap_lvl_d = iack_lvl;
        end
      end
      LOOKUP: begin
        state_d = RESP;
        vld_d   = 1'b1;
        if (hit) begin
          vec_d = VEC_BASE + {6'b0, hit_idx};
          ack_d = 4'b0001 << hit_idx;
        end else begin
          vec_d = SPUR_VEC;
        end
      end
      RESP:    state_d = WAIT;
      WAIT:    if (!iack_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, output and priority registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cap_lvl_q <= '0;
      vec_q     <= 8'h00;
      vld_q     <= 1'b0;
      ack_q     <= 4'b0;
      ipl_q     <= 3'b111;
    end else begin
      state_q   <= state_d;
      cap_lvl_q <= cap_lvl_d;
      vec_q     <= vec_d;
      vld_q     <= vld_d;
      ack_q     <= ack_d;
      ipl_q     <= ipl_d;
    end
  end

  assign ipl_n     = ipl_q;
  assign vec       = vec_q;
  assign vec_valid = vld_q;
  assign ack_src   = ack_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: priority encoding, acknowledge responses, reset abort.
// Inputs driven 1 time unit after the rising edge; outputs sampled at that point.
// Every expected value below is hand-derived from the register map and timing.
module tb_irq_ctrl;
  logic       clk;
  logic       rst;
  logic [3:0] irq_n;
  logic [2:0] ipl_n;
  logic       iack_req;
  logic [2:0] iack_lvl;
  logic [7:0] vec;
  logic       vec_valid;
  logic [3:0] ack_src;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_n(irq_n), .ipl_n(ipl_n),
    .iack_req(iack_req), .iack_lvl(iack_lvl), .vec(vec),
    .vec_valid(vec_valid), .ack_src(ack_src), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, {24'b0, cfg_rdata}, {24'b0, exp});
  endtask

  initial begin
    int pulses;
    rst = 1'b1; irq_n = 4'hF; iack_req = 1'b0; iack_lvl = 3'd0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00;
    cyc(2);
    rst = 1'b0;

    // Reset state
    chk("rst_ipl", {29'b0, ipl_n}, 32'h7);
    chk("rst_vec", {24'b0, vec}, 32'h00);
    chk("rst_vld", {31'b0, vec_valid}, 32'h0);
    chk("rst_ack", {28'b0, ack_src}, 32'h0);
    rd_chk("rst_mask", 2'd0, 8'h00);
    rd_chk("rst_lvl01", 2'd2, 8'h00);

    // Single source, level 5: three-edge latency both ways
    wr(2'd2, 8'h05);
    wr(2'd0, 8'h01);
    rd_chk("lvl01_rb", 2'd2, 8'h05);
    irq_n = 4'b1110;
    cyc(2);
    chk("lat_2edges", {29'b0, ipl_n}, 32'h7);
    cyc(1);
    chk("lat_3edges", {29'b0, ipl_n}, 32'h2);
    rd_chk("pend_src0", 2'd1, 8'h01);
    irq_n = 4'b1111;
    cyc(2);
    chk("rel_2edges", {29'b0, ipl_n}, 32'h2);
    cyc(1);
    chk("rel_3edges", {29'b0, ipl_n}, 32'h7);

    // Levels 3 and 6 pending, acknowledge level 6
    wr(2'd2, 8'h35);
    wr(2'd3, 8'h06);
    wr(2'd0, 8'h06);
    irq_n = 4'b1001;
    cyc(3);
    chk("ipl_max6", {29'b0, ipl_n}, 32'h1);
    iack_req = 1'b1; iack_lvl = 3'd6;
    cyc(1);
    chk("lookup_novld", {31'b0, vec_valid}, 32'h0);
    cyc(1);
    chk("ack6_vec", {24'b0, vec}, 32'h42);
    chk("ack6_vld", {31'b0, vec_valid}, 32'h1);
    chk("ack6_src", {28'b0, ack_src}, 32'h4);
    iack_req = 1'b0;
    cyc(1);
    chk("wait_vld0", {31'b0, vec_valid}, 32'h0);
    chk("wait_ack0", {28'b0, ack_src}, 32'h0);
    chk("vec_hold", {24'b0, vec}, 32'h42);
    cyc(1);

    // Same-level tie between sources 0 and 3
    irq_n = 4'b1111;
    wr(2'd2, 8'h04);
    wr(2'd3, 8'h40);
    wr(2'd0, 8'h09);
    irq_n = 4'b0110;
    cyc(3);
    chk("ipl_tie4", {29'b0, ipl_n}, 32'h3);
    iack_req = 1'b1; iack_lvl = 3'd4;
    cyc(2);
    chk("tie_vec", {24'b0, vec}, 32'h40);
    chk("tie_src", {28'b0, ack_src}, 32'h1);
    chk("tie_ipl", {29'b0, ipl_n}, 32'h3);
    iack_req = 1'b0;
    cyc(2);
    irq_n = 4'b0111;
    cyc(3);
    chk("ipl_src3_only", {29'b0, ipl_n}, 32'h3);

    // No level-2 source: spurious vector; held request gives a single pulse
    iack_req = 1'b1; iack_lvl = 3'd2;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (vec_valid) begin
        pulses++;
        chk("spur_vec", {24'b0, vec}, 32'h18);
        chk("spur_ack", {28'b0, ack_src}, 32'h0);
      end
    end
    chk("held_pulses", pulses, 1);
    iack_req = 1'b0;
    cyc(1);
    iack_req = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (vec_valid) pulses++;
    end
    chk("second_pulses", pulses, 1);
    iack_req = 1'b0;
    cyc(1);

    // Mask cleared on the LOOKUP edge: lookup still sees source 3
    iack_req = 1'b1; iack_lvl = 3'd4;
    cyc(1);
    wr(2'd0, 8'h00);
    chk("lkwr_vec", {24'b0, vec}, 32'h43);
    chk("lkwr_src", {28'b0, ack_src}, 32'h8);
    chk("lkwr_ipl_old", {29'b0, ipl_n}, 32'h3);
    rd_chk("lkwr_pend", 2'd1, 8'h00);
    iack_req = 1'b0;
    cyc(1);
    chk("lkwr_ipl_new", {29'b0, ipl_n}, 32'h7);

    // Reset while in LOOKUP aborts the acknowledge
    wr(2'd0, 8'h08);
    cyc(2);
    chk("pre_rst_ipl", {29'b0, ipl_n}, 32'h3);
    iack_req = 1'b1; iack_lvl = 3'd4;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; iack_req = 1'b0;
    chk("abort_ipl", {29'b0, ipl_n}, 32'h7);
    chk("abort_vec", {24'b0, vec}, 32'h00);
    rd_chk("abort_mask", 2'd0, 8'h00);
    rd_chk("abort_pend", 2'd1, 8'h00);
    rd_chk("abort_lvl01", 2'd2, 8'h00);
    rd_chk("abort_lvl23", 2'd3, 8'h00);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (vec_valid || (ack_src != 4'b0)) pulses++;
      cyc(1);
    end
    chk("abort_no_pulse", pulses, 0);
    iack_req = 1'b1; iack_lvl = 3'd4;
    cyc(2);
    chk("post_rst_vld", {31'b0, vec_valid}, 32'h1);
    chk("post_rst_vec", {24'b0, vec}, 32'h18);
    iack_req = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
